// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO controller: state encoding, default widths, depth helper.
package stack_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 5;
    localparam int RAM_LAT_DEF = 1;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEPTH = depth_of(ADDR_W_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_e;
endpackage

// File: rtl/stack_ctrl_if.sv
// User-side request/response bundle of the stack controller.
interface stack_ctrl_if
    import stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output push, pop, din,
        input  busy, dout, dout_valid, full, empty, count, err_ovf, err_udf
    );

    modport slave (
        input  push, pop, din,
        output busy, dout, dout_valid, full, empty, count, err_ovf, err_udf
    );
endinterface

// File: rtl/stack_8bit.sv
// Single-port synchronous RAM: address registered on the clock, read data one edge later.
module stack_8bit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wren_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk_i) begin
        addr_q <= addr_i;
        if (wren_i) mem[addr_i] <= data_i;
    end

    assign q_o = mem[addr_q];
endmodule

// File: rtl/stack_ptr.sv
// Stack occupancy counter (0..DEPTH) with full/empty flags; inc/dec are ignored at the limits.
module stack_ptr
    import stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            dec_i,
    input  logic            clr_i,
    output logic [ADDR_W:0] count_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(depth_of(ADDR_W));

    logic [ADDR_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                   cnt_d = '0;
        else if (inc_i && !full_o)   cnt_d = cnt_q + (ADDR_W+1)'(1);
        else if (dec_i && !empty_o)  cnt_d = cnt_q - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller: turns one-cycle push/pop requests into write/read sequences on an external RAM.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    stack_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_wren_o,
    input  logic [DATA_W-1:0] ram_q_i
);
    localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              inc, dec;
    logic [ADDR_W:0]   count;
    logic              full, empty;

    stack_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc),
        .dec_i   (dec),
        .clr_i   (1'b0),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Requests are only looked at in IDLE; push has priority over pop.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        dout_d  = dout_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.push) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        inc     = 1'b1;
                        addr_d  = count[ADDR_W-1:0];
                        data_d  = bus.din;
                        wren_d  = 1'b1;
                        state_d = ST_WRITE;
                    end
                end else if (bus.pop) begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        dec     = 1'b1;
                        addr_d  = count[ADDR_W-1:0] - ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                wait_d  = WAIT_W'(RAM_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    dout_d  = ram_q_i;
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign ram_addr_o     = addr_q;
    assign ram_data_o     = data_q;
    assign ram_wren_o     = wren_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == ST_CAPTURE);
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count;
    assign bus.err_ovf    = ovf_q;
    assign bus.err_udf    = udf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl + stack_8bit: schedule-based LIFO model checked every cycle, plus directed literals.
module tb_stack_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;

    stack_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    stack_ctrl #(.DATA_W(8), .ADDR_W(5), .RAM_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data),
        .ram_wren_o (ram_wren),
        .ram_q_i    (ram_q)
    );

    stack_8bit #(.DATA_W(8), .ADDR_W(5)) u_ram (
        .clk_i  (clk),
        .addr_i (ram_addr),
        .data_i (ram_data),
        .wren_i (ram_wren),
        .q_o    (ram_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: stack contents as a queue plus the cycles at which each visible event is due.
    int          cyc = 0;
    int          busy_until = -1, wr_cyc = -1, rd_cyc = -1, cap_cyc = -1, ovf_cyc = -1, udf_cyc = -1;
    int          wr_addr, wr_data, rd_addr, cap_val;
    int          mdout = 0;
    int          stk[$];

    always @(negedge clk) begin
        if (rst) begin
            stk.delete();
            busy_until = -1; wr_cyc = -1; rd_cyc = -1; cap_cyc = -1; ovf_cyc = -1; udf_cyc = -1;
            mdout = 0;
            chk("rst_busy",  bus.busy, 0);
            chk("rst_count", bus.count, 0);
            chk("rst_empty", bus.empty, 1);
            chk("rst_full",  bus.full, 0);
            chk("rst_valid", bus.dout_valid, 0);
            chk("rst_dout",  bus.dout, 0);
            chk("rst_wren",  ram_wren, 0);
            chk("rst_addr",  ram_addr, 0);
            chk("rst_ovf",   bus.err_ovf, 0);
            chk("rst_udf",   bus.err_udf, 0);
        end else begin
            if (cyc == cap_cyc) mdout = cap_val;
            chk("busy",  bus.busy, int'(cyc <= busy_until));
            chk("count", bus.count, stk.size());
            chk("full",  bus.full, int'(stk.size() == 32));
            chk("empty", bus.empty, int'(stk.size() == 0));
            chk("wren",  ram_wren, int'(cyc == wr_cyc));
            if (cyc == wr_cyc) begin
                chk("wr_addr", ram_addr, wr_addr);
                chk("wr_data", ram_data, wr_data);
            end
            if (cyc == rd_cyc) chk("rd_addr", ram_addr, rd_addr);
            chk("dout_valid", bus.dout_valid, int'(cyc == cap_cyc));
            chk("dout",    bus.dout, mdout);
            chk("err_ovf", bus.err_ovf, int'(cyc == ovf_cyc));
            chk("err_udf", bus.err_udf, int'(cyc == udf_cyc));
            if (cyc > busy_until) begin
                if (bus.push) begin
                    if (stk.size() == 32) ovf_cyc = cyc + 1;
                    else begin
                        wr_cyc = cyc + 1; wr_addr = stk.size(); wr_data = int'(bus.din);
                        stk.push_back(int'(bus.din));
                        busy_until = cyc + 1;
                    end
                end else if (bus.pop) begin
                    if (stk.size() == 0) udf_cyc = cyc + 1;
                    else begin
                        rd_cyc = cyc + 1; rd_addr = stk.size() - 1;
                        cap_val = stk.pop_back();
                        cap_cyc = cyc + 3;
                        busy_until = cyc + 3;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic drive(input bit p, input bit o, input logic [7:0] d);
        @(posedge clk); #1;
        bus.push = p; bus.pop = o; bus.din = d;
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (k == 10) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    task automatic pop_expect(input int exp);
        int k;
        bit seen;
        seen = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        for (k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.dout_valid) begin seen = 1'b1; break; end
        end
        if (seen) begin
            chk("pop_dout", bus.dout, exp);
            chk("pop_latency", k, 3);
        end else begin
            total++; bad++;
            $display("FAIL pop_timeout actual=no_valid required=valid t=%0t", $time);
        end
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int pp, op;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: three pushes
        drive(1'b1, 1'b0, 8'h12); wait_idle();
        drive(1'b1, 1'b0, 8'h77); wait_idle();
        drive(1'b1, 1'b0, 8'h69); wait_idle();
        chk("t1_count", bus.count, 3);
        chk("t1_ram0", u_ram.mem[0], 8'h12);
        chk("t1_ram1", u_ram.mem[1], 8'h77);
        chk("t1_ram2", u_ram.mem[2], 8'h69);

        // 2: three pops in LIFO order
        pop_expect(8'h69);
        pop_expect(8'h77);
        pop_expect(8'h12);
        chk("t2_empty", bus.empty, 1);

        // 3: pop on empty
        drive(1'b0, 1'b1, 8'h00);
        @(negedge clk);
        chk("t3_udf", bus.err_udf, 1);
        chk("t3_wren", ram_wren, 0);
        chk("t3_count", bus.count, 0);

        // 4: fill, then overflow
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 8'(i)); wait_idle();
        end
        chk("t4_full", bus.full, 1);
        drive(1'b1, 1'b0, 8'hAA);
        @(negedge clk);
        chk("t4_ovf", bus.err_ovf, 1);
        chk("t4_wren", ram_wren, 0);
        chk("t4_count", bus.count, 32);
        chk("t4_ram31", u_ram.mem[31], 8'h1F);

        // 5: push and pop together with one entry held
        do_reset();
        drive(1'b1, 1'b0, 8'h33); wait_idle();
        drive(1'b1, 1'b1, 8'h44); wait_idle();
        chk("t5_count", bus.count, 2);
        chk("t5_ram1", u_ram.mem[1], 8'h44);

        // 6: reset during READ, then during WAIT
        for (int d = 0; d < 2; d++) begin
            drive(1'b0, 1'b1, 8'h00);
            repeat (d) @(posedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            chk("t6_busy", bus.busy, 0);
            chk("t6_count", bus.count, 0);
            chk("t6_valid", bus.dout_valid, 0);
            chk("t6_wren", ram_wren, 0);
            @(posedge clk); #1 rst = 1'b0;
            repeat (3) @(negedge clk);
            chk("t6_valid_after", bus.dout_valid, 0);
            drive(1'b1, 1'b0, 8'h5A); wait_idle();
            drive(1'b1, 1'b0, 8'hA5); wait_idle();
        end

        // Random traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 6; ph++) begin
            pp = (ph % 2 == 0) ? 75 : 25;
            op = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 500; i++) begin
                @(posedge clk); #1;
                bus.push = ($urandom_range(99) < pp);
                bus.pop  = ($urandom_range(99) < op);
                bus.din  = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
